// File: rtl/sram_access_arbiter_if.sv
// Bus bundle for sram_access_arbiter: writer strobes, read client handshake and SRAM pins.
// The slave modport is the arbiter; the master modport is its environment.
interface sram_access_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 16
);
   logic              selec_in_sram;
   logic              write_in_sram;
   logic [DATA_W-1:0] data_wr_in_in_sram;
   logic [ADDR_W-1:0] addr_wr_in_sram;

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic [DATA_W-1:0] sram_dq_in;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              sram_ub_n;
   logic              sram_lb_n;

   logic              busy;
   logic              wr_overflow;

   modport slave (
      input  selec_in_sram, write_in_sram, data_wr_in_in_sram, addr_wr_in_sram,
      input  rd_req, rd_addr, sram_dq_in,
      output rd_ack, rd_valid, rd_data,
      output sram_addr, sram_dq_out, sram_dq_oe,
      output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      output busy, wr_overflow
   );

   modport master (
      output selec_in_sram, write_in_sram, data_wr_in_in_sram, addr_wr_in_sram,
      output rd_req, rd_addr, sram_dq_in,
      input  rd_ack, rd_valid, rd_data,
      input  sram_addr, sram_dq_out, sram_dq_oe,
      input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
      input  busy, wr_overflow
   );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares one 16-bit SRAM between a strobe-style camera writer (via a 2-entry FIFO)
// and a read client; write-priority arbitration with a read anti-starvation limit.
module sram_access_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic                 wclk,
   input  logic                 rst,
   sram_access_arbiter_if.slave sram_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_SETUP,
      S_WR_PULSE,
      S_RD_ADDR,
      S_RD_SAMPLE
   } state_t;

   localparam int           ENT_W      = ADDR_W + DATA_W;
   localparam logic [2:0]   STARVE_LIM = 3'(STARVE_MAX);

   state_t            state;
   state_t            state_nxt;

   logic              w_p0;
   logic [ADDR_W-1:0] addr_p0;

   logic [ENT_W-1:0]  fifo0;
   logic [ENT_W-1:0]  fifo1;
   logic [1:0]        fifo_cnt;
   logic [2:0]        starve_cnt;

   logic              w;
   logic              cap;
   logic              pop;
   logic              push;
   logic              drop;
   logic              decide;
   logic              grant_wr;
   logic              grant_rd;
   logic [ENT_W-1:0]  wr_ent;
   logic [ENT_W-1:0]  fifo0_nxt;
   logic [ENT_W-1:0]  fifo1_nxt;
   logic [1:0]        cnt_nxt;
   logic [2:0]        starve_nxt;

   // Capture: a new write is a rising w or an address change while w is held.
   always_comb begin
      w      = sram_bus.selec_in_sram & sram_bus.write_in_sram;
      cap    = w & (~w_p0 | (sram_bus.addr_wr_in_sram != addr_p0));
      wr_ent = {sram_bus.addr_wr_in_sram, sram_bus.data_wr_in_in_sram};
      pop    = (state == S_WR_PULSE);
      push   = cap & ((fifo_cnt != 2'd2) | pop);
      drop   = cap & ~push;

      fifo0_nxt = fifo0;
      fifo1_nxt = fifo1;
      cnt_nxt   = fifo_cnt;
      case ({pop, push})
         2'b10: begin
            fifo0_nxt = fifo1;
            cnt_nxt   = fifo_cnt - 2'd1;
         end
         2'b01: begin
            if (fifo_cnt == 2'd0) fifo0_nxt = wr_ent;
            else                  fifo1_nxt = wr_ent;
            cnt_nxt = fifo_cnt + 2'd1;
         end
         2'b11: begin
            if (fifo_cnt == 2'd1) begin
               fifo0_nxt = wr_ent;
            end else begin
               fifo0_nxt = fifo1;
               fifo1_nxt = wr_ent;
            end
         end
         default: ;
      endcase
   end

   // Arbitration sees the FIFO as it will be after this edge's pop/push, so a
   // capture on the decision edge is granted without an idle cycle.
   always_comb begin
      decide   = (state == S_IDLE) | (state == S_WR_PULSE) | (state == S_RD_SAMPLE);
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      case (state)
         S_WR_SETUP: state_nxt = S_WR_PULSE;
         S_RD_ADDR:  state_nxt = S_RD_SAMPLE;
         default:    state_nxt = S_IDLE;
      endcase
      if (decide) begin
         if ((cnt_nxt != 2'd0) && (starve_cnt < STARVE_LIM)) grant_wr = 1'b1;
         else if (sram_bus.rd_req)                           grant_rd = 1'b1;
         else if (cnt_nxt != 2'd0)                           grant_wr = 1'b1;
         if (grant_wr)      state_nxt = S_WR_SETUP;
         else if (grant_rd) state_nxt = S_RD_ADDR;
      end

      if (!sram_bus.rd_req)                          starve_nxt = 3'd0;
      else if (grant_rd)                             starve_nxt = 3'd0;
      else if (grant_wr && (starve_cnt != 3'd7))     starve_nxt = starve_cnt + 3'd1;
      else                                           starve_nxt = starve_cnt;
   end

   always_ff @(posedge wclk) begin
      fifo0 <= fifo0_nxt;
      fifo1 <= fifo1_nxt;
   end

   // Registered FSM: every SRAM pin is set from the state being entered.
   always_ff @(posedge wclk or negedge rst) begin
      if (!rst) begin
         state                <= S_IDLE;
         w_p0                 <= 1'b0;
         addr_p0              <= '0;
         fifo_cnt             <= 2'd0;
         starve_cnt           <= 3'd0;
         sram_bus.sram_addr   <= '0;
         sram_bus.sram_dq_out <= '0;
         sram_bus.sram_dq_oe  <= 1'b0;
         sram_bus.sram_ce_n   <= 1'b1;
         sram_bus.sram_we_n   <= 1'b1;
         sram_bus.sram_oe_n   <= 1'b1;
         sram_bus.sram_ub_n   <= 1'b1;
         sram_bus.sram_lb_n   <= 1'b1;
         sram_bus.rd_ack      <= 1'b0;
         sram_bus.rd_valid    <= 1'b0;
         sram_bus.rd_data     <= '0;
         sram_bus.busy        <= 1'b0;
         sram_bus.wr_overflow <= 1'b0;
      end else begin
         state      <= state_nxt;
         w_p0       <= w;
         addr_p0    <= sram_bus.addr_wr_in_sram;
         fifo_cnt   <= cnt_nxt;
         starve_cnt <= starve_nxt;

         sram_bus.rd_ack   <= 1'b0;
         sram_bus.rd_valid <= (state == S_RD_SAMPLE);
         if (state == S_RD_SAMPLE) sram_bus.rd_data <= sram_bus.sram_dq_in;
         if (drop) sram_bus.wr_overflow <= 1'b1;
         sram_bus.busy <= (state_nxt != S_IDLE) | (cnt_nxt != 2'd0);

         case (state_nxt)
            S_WR_SETUP: begin
               sram_bus.sram_addr   <= fifo0_nxt[ENT_W-1:DATA_W];
               sram_bus.sram_dq_out <= fifo0_nxt[DATA_W-1:0];
               sram_bus.sram_dq_oe  <= 1'b1;
               sram_bus.sram_ce_n   <= 1'b0;
               sram_bus.sram_we_n   <= 1'b1;
               sram_bus.sram_oe_n   <= 1'b1;
               sram_bus.sram_ub_n   <= 1'b0;
               sram_bus.sram_lb_n   <= 1'b0;
            end
            S_WR_PULSE: begin
               sram_bus.sram_we_n   <= 1'b0;
            end
            S_RD_ADDR: begin
               sram_bus.sram_addr   <= sram_bus.rd_addr;
               sram_bus.sram_dq_oe  <= 1'b0;
               sram_bus.sram_ce_n   <= 1'b0;
               sram_bus.sram_we_n   <= 1'b1;
               sram_bus.sram_oe_n   <= 1'b0;
               sram_bus.sram_ub_n   <= 1'b0;
               sram_bus.sram_lb_n   <= 1'b0;
               sram_bus.rd_ack      <= 1'b1;
            end
            S_RD_SAMPLE: ;
            default: begin
               sram_bus.sram_dq_oe  <= 1'b0;
               sram_bus.sram_ce_n   <= 1'b1;
               sram_bus.sram_we_n   <= 1'b1;
               sram_bus.sram_oe_n   <= 1'b1;
               sram_bus.sram_ub_n   <= 1'b1;
               sram_bus.sram_lb_n   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: directed scenarios plus random traffic, checked every
// cycle against a queue-based transaction model and a pin-driven SRAM array.
module tb_sram_access_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;
   localparam int SMAX   = 4;

   logic wclk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b1;

   sram_access_arbiter_if bus_if ();

   sram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
      .wclk     (wclk),
      .rst      (rst_n),
      .sram_bus (bus_if)
   );

   always #5 wclk = ~wclk;

   // Physical SRAM, driven only by the DUT pins.
   logic [DATA_W-1:0] phys    [0:1023];
   logic [DATA_W-1:0] ref_mem [0:1023];
   assign bus_if.sram_dq_in = phys[bus_if.sram_addr[9:0]];
   always @(posedge wclk)
      if (!bus_if.sram_ce_n && !bus_if.sram_we_n) phys[bus_if.sram_addr[9:0]] <= bus_if.sram_dq_out;

   logic [ADDR_W-1:0] wr_log[$];
   always @(negedge wclk) if (!bus_if.sram_we_n) wr_log.push_back(bus_if.sram_addr);

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transaction model: pending writes as a queue, current access as kind + phase.
   logic [ADDR_W+DATA_W-1:0] mq[$];
   int                acc = 0;  // 0 none, 1 write, 2 read
   int                ph  = 0;
   int                starve = 0;
   logic              m_wprev = 1'b0;
   logic [ADDR_W-1:0] m_aprev = '0;
   logic [ADDR_W-1:0] e_addr = '0;
   logic [DATA_W-1:0] e_dq = '0, e_rdata = '0;
   logic e_oe = 0, e_ce_n = 1, e_we_n = 1, e_oe_n = 1, e_ack = 0, e_valid = 0, e_busy = 0, e_ovf = 0;

   task automatic model_reset();
      mq.delete();
      acc = 0; ph = 0; starve = 0; m_wprev = 1'b0; m_aprev = '0;
      e_addr = '0; e_dq = '0; e_rdata = '0;
      e_oe = 0; e_ce_n = 1; e_we_n = 1; e_oe_n = 1; e_ack = 0; e_valid = 0; e_busy = 0; e_ovf = 0;
   endtask

   task automatic model_step();
      logic w, cap, gw, gr, decide;
      logic [ADDR_W+DATA_W-1:0] ent;
      w   = bus_if.selec_in_sram & bus_if.write_in_sram;
      cap = w && (!m_wprev || bus_if.addr_wr_in_sram != m_aprev);
      m_wprev = w;
      m_aprev = bus_if.addr_wr_in_sram;
      e_ack = 0; e_valid = 0;
      if (acc == 2 && ph == 1) begin
         e_valid = 1;
         e_rdata = ref_mem[e_addr[9:0]];
      end
      if (acc == 1 && ph == 1) begin
         ent = mq.pop_front();
         ref_mem[ent[DATA_W+9:DATA_W]] = ent[DATA_W-1:0];
      end
      if (cap) begin
         if (mq.size() < 2) mq.push_back({bus_if.addr_wr_in_sram, bus_if.data_wr_in_in_sram});
         else e_ovf = 1;
      end
      decide = (acc == 0) || (ph == 1);
      gw = 0; gr = 0;
      if (decide) begin
         if (mq.size() > 0 && starve < SMAX) gw = 1;
         else if (bus_if.rd_req)             gr = 1;
         else if (mq.size() > 0)             gw = 1;
         if (gw) begin
            ent = mq[0];
            acc = 1; ph = 0;
            e_addr = ent[ADDR_W+DATA_W-1:DATA_W]; e_dq = ent[DATA_W-1:0];
            e_oe = 1; e_ce_n = 0; e_we_n = 1; e_oe_n = 1;
         end else if (gr) begin
            acc = 2; ph = 0;
            e_addr = bus_if.rd_addr;
            e_oe = 0; e_ce_n = 0; e_we_n = 1; e_oe_n = 0; e_ack = 1;
         end else begin
            acc = 0; ph = 0;
            e_oe = 0; e_ce_n = 1; e_we_n = 1; e_oe_n = 1;
         end
      end else begin
         ph = 1;
         if (acc == 1) e_we_n = 0;
      end
      if (!bus_if.rd_req)            starve = 0;
      else if (gr)                   starve = 0;
      else if (gw && starve < 7)     starve = starve + 1;
      e_busy = (acc != 0) || (mq.size() != 0);
   endtask

   always @(posedge wclk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge wclk) if (chk_en) begin
      check_val("ctrl", 32'({bus_if.sram_ce_n, bus_if.sram_we_n, bus_if.sram_oe_n,
                             bus_if.sram_ub_n, bus_if.sram_lb_n, bus_if.sram_dq_oe}),
                        32'({e_ce_n, e_we_n, e_oe_n, e_ce_n, e_ce_n, e_oe}));
      check_val("sram_addr",   32'(bus_if.sram_addr),   32'(e_addr));
      check_val("sram_dq_out", 32'(bus_if.sram_dq_out), 32'(e_dq));
      check_val("rd_ack",      32'(bus_if.rd_ack),      32'(e_ack));
      check_val("rd_valid",    32'(bus_if.rd_valid),    32'(e_valid));
      check_val("rd_data",     32'(bus_if.rd_data),     32'(e_rdata));
      check_val("busy",        32'(bus_if.busy),        32'(e_busy));
      check_val("wr_overflow", 32'(bus_if.wr_overflow), 32'(e_ovf));
      check_val("dq_oe_with_oe_n", 32'(bus_if.sram_dq_oe & ~bus_if.sram_oe_n), 32'd0);
   end

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && bus_if.busy; i++) step();
      check_val("wait_idle", 32'(bus_if.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wr_before, n_wr, base;
      bit got_ack, vseen;
      for (int i = 0; i < 1024; i++) begin
         phys[i]    = DATA_W'(i * 3 + 7);
         ref_mem[i] = DATA_W'(i * 3 + 7);
      end
      phys[16'h10] = 16'h1234;
      ref_mem[16'h10] = 16'h1234;
      bus_if.selec_in_sram = 0; bus_if.write_in_sram = 0;
      bus_if.addr_wr_in_sram = '0; bus_if.data_wr_in_in_sram = '0;
      bus_if.rd_req = 0; bus_if.rd_addr = '0;
      rst_n = 1'b0;
      repeat (3) step();
      check_val("rst_ce_we_oe_n", 32'({bus_if.sram_ce_n, bus_if.sram_we_n, bus_if.sram_oe_n}), 32'h7);
      check_val("rst_busy_ovf", 32'({bus_if.busy, bus_if.wr_overflow, bus_if.rd_valid}), 32'h0);
      rst_n = 1'b1;
      step();

      // Single write
      bus_if.selec_in_sram = 1; bus_if.write_in_sram = 1;
      bus_if.addr_wr_in_sram = 19'h00005; bus_if.data_wr_in_in_sram = 16'hA5A5;
      step();
      check_val("wr_setup", 32'({bus_if.sram_ce_n, bus_if.sram_we_n, bus_if.sram_oe_n, bus_if.sram_dq_oe}), 32'b0111);
      bus_if.write_in_sram = 0;
      step();
      check_val("wr_pulse_we_n", 32'(bus_if.sram_we_n), 32'd0);
      check_val("wr_pulse_addr", 32'(bus_if.sram_addr), 32'h5);
      check_val("wr_pulse_dq",   32'(bus_if.sram_dq_out), 32'hA5A5);
      step();
      check_val("wr_done", 32'({bus_if.sram_ce_n, bus_if.busy}), 32'b10);

      // Single read
      bus_if.rd_addr = 19'h10; bus_if.rd_req = 1;
      step();
      check_val("rd_ack_lat", 32'({bus_if.rd_ack, bus_if.sram_oe_n}), 32'b10);
      bus_if.rd_req = 0;
      step();
      check_val("rd_sample", 32'({bus_if.rd_ack, bus_if.sram_oe_n}), 32'b00);
      step();
      check_val("rd_valid_lat", 32'({bus_if.rd_valid, bus_if.sram_oe_n}), 32'b11);
      check_val("rd_data_1234", 32'(bus_if.rd_data), 32'h1234);

      // Write/read collision on the same address
      bus_if.rd_addr = 19'h20; bus_if.rd_req = 1;
      bus_if.write_in_sram = 1; bus_if.addr_wr_in_sram = 19'h20; bus_if.data_wr_in_in_sram = 16'hBEEF;
      step();
      check_val("col_wr_first", 32'({bus_if.sram_ce_n, bus_if.sram_we_n, bus_if.sram_oe_n}), 32'b011);
      bus_if.write_in_sram = 0;
      step();
      check_val("col_wr_pulse", 32'(bus_if.sram_we_n), 32'd0);
      step();
      check_val("col_rd_ack", 32'(bus_if.rd_ack), 32'd1);
      bus_if.rd_req = 0;
      step(); step();
      check_val("col_rd_valid", 32'(bus_if.rd_valid), 32'd1);
      check_val("col_rd_data", 32'(bus_if.rd_data), 32'hBEEF);
      wait_idle();

      // Starvation limit: writes every 2 cycles with a read held pending
      bus_if.rd_addr = 19'h30; bus_if.rd_req = 1;
      n_wr = 0; got_ack = 0; wr_before = -1;
      for (int i = 0; i < 20; i++) begin
         bus_if.write_in_sram = (i % 2 == 0);
         bus_if.addr_wr_in_sram = ADDR_W'(32'h40 + i);
         bus_if.data_wr_in_in_sram = DATA_W'($urandom);
         step();
         if (!bus_if.sram_we_n && !got_ack) n_wr++;
         if (bus_if.rd_ack && !got_ack) begin
            got_ack = 1; wr_before = n_wr; bus_if.rd_req = 0;
         end
      end
      bus_if.write_in_sram = 0;
      check_val("starve_grants", 32'(wr_before), 32'd4);
      wait_idle();
      check_val("starve_no_ovf", 32'(bus_if.wr_overflow), 32'd0);

      // Overflow: three captures back-to-back while a read is in flight
      base = wr_log.size();
      bus_if.rd_addr = 19'h50; bus_if.rd_req = 1;
      step();
      check_val("ovf_rd_ack", 32'(bus_if.rd_ack), 32'd1);
      bus_if.rd_req = 0;
      bus_if.write_in_sram = 1; bus_if.addr_wr_in_sram = 19'h61; bus_if.data_wr_in_in_sram = 16'h1111;
      step();
      bus_if.addr_wr_in_sram = 19'h62; bus_if.data_wr_in_in_sram = 16'h2222;
      step();
      bus_if.addr_wr_in_sram = 19'h63; bus_if.data_wr_in_in_sram = 16'h3333;
      step();
      bus_if.write_in_sram = 0;
      check_val("ovf_set", 32'(bus_if.wr_overflow), 32'd1);
      wait_idle();
      check_val("ovf_sticky", 32'(bus_if.wr_overflow), 32'd1);
      check_val("ovf_wr_count", 32'(wr_log.size() - base), 32'd2);
      if (wr_log.size() >= base + 2) begin
         check_val("ovf_wr0_addr", 32'(wr_log[base]),     32'h61);
         check_val("ovf_wr1_addr", 32'(wr_log[base + 1]), 32'h62);
      end
      check_val("ovf_mem", 32'({phys[16'h61], phys[16'h62]}), 32'h11112222);

      // Reset during S_RD_SAMPLE
      bus_if.rd_addr = 19'h10; bus_if.rd_req = 1;
      step();
      bus_if.rd_req = 0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check_val("rstmid_ce_oe_n", 32'({bus_if.sram_ce_n, bus_if.sram_oe_n}), 32'b11);
      check_val("rstmid_ovf", 32'(bus_if.wr_overflow), 32'd0);
      vseen = 0;
      repeat (3) begin step(); vseen |= bus_if.rd_valid; end
      rst_n = 1'b1;
      repeat (4) begin step(); vseen |= bus_if.rd_valid; end
      check_val("rstmid_no_valid", 32'(vseen), 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if (bus_if.rd_ack) bus_if.rd_req = 0;
         else if (!bus_if.rd_req && ($urandom % 4 == 0)) begin
            bus_if.rd_req = 1;
            bus_if.rd_addr = ADDR_W'($urandom_range(0, 1023));
         end
         bus_if.selec_in_sram = ($urandom % 8 != 0);
         bus_if.write_in_sram = ($urandom % 2 == 1);
         if ($urandom % 2 == 0) bus_if.addr_wr_in_sram = ADDR_W'($urandom_range(0, 1023));
         bus_if.data_wr_in_in_sram = DATA_W'($urandom);
         step();
      end
      bus_if.write_in_sram = 0;
      for (int i = 0; i < 20 && bus_if.rd_req; i++) begin
         if (bus_if.rd_ack) bus_if.rd_req = 0;
         step();
      end
      check_val("final_rd_req_done", 32'(bus_if.rd_req), 32'd0);
      wait_idle();
      step();

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
